cx_arbiter: RTL and testbench

- Shares one compare-and-exchange register bank among CORES requesters, for example the cores of a multi-core CPU.
- Serialises requests so that no two exchanges ever overlap, giving each one atomicity.
- Zero-fills the bank after reset.
- Contains the bank as a sub-module with an explicit enable; the bank never writes unless the arbiter commands it.

---
 rtl/cx_arbiter_pkg.sv | 16 +
 rtl/cx_arbiter_if.sv | 43 ++++
 rtl/cx_bank.sv | 32 +++
 rtl/cx_arbiter.sv | 150 +++++++++++++++
 tb/tb_cx_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cx_arbiter_pkg.sv
// Shared types and defaults for the compare-and-exchange arbiter and its register bank.
package cx_arbiter_pkg;

    localparam int unsigned CX_CORES      = 2;
    localparam int unsigned CX_INDEX_BITS = 8;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StAccess,
        StRespond
    } cx_state_t;

endpackage

// File: rtl/cx_arbiter_if.sv
// Requester-side bundle of the compare-and-exchange arbiter: per-core operands in, result out.
interface cx_arbiter_if
    import cx_arbiter_pkg::*;
#(
    parameter int unsigned CORES      = CX_CORES,
    parameter int unsigned INDEX_BITS = CX_INDEX_BITS
) ();

    logic    [CORES-1:0]                 request;
    logic    [CORES-1:0][INDEX_BITS-1:0] index;
    regval_t [CORES-1:0]                 comparand;
    regval_t [CORES-1:0]                 replacement;
    logic    [CORES-1:0]                 grant;
    logic    [CORES-1:0]                 done;
    regval_t                             original;
    logic                                swapped;
    logic                                ready;

    modport master (
        output request,
        output index,
        output comparand,
        output replacement,
        input  grant,
        input  done,
        input  original,
        input  swapped,
        input  ready
    );

    modport slave (
        input  request,
        input  index,
        input  comparand,
        input  replacement,
        output grant,
        output done,
        output original,
        output swapped,
        output ready
    );

endinterface

// File: rtl/cx_bank.sv
// Single-port compare-and-exchange register bank; registered read, writes only when commanded.
module cx_bank
    import cx_arbiter_pkg::*;
#(
    parameter int unsigned INDEX_BITS = CX_INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  enable,
    input  logic                  write_zero,
    input  logic [INDEX_BITS-1:0] index,
    input  regval_t               comparand,
    input  regval_t               replacement,
    output regval_t               original
);

    localparam int unsigned Depth = 2 ** INDEX_BITS;

    regval_t mem_q [Depth];

    // Contents are deliberately not reset; the arbiter zero-fills them through write_zero.
    always_ff @(posedge clock) begin
        if (write_zero) begin
            mem_q[index] <= '0;
        end else if (enable) begin
            original <= mem_q[index];
            if (mem_q[index] == comparand) begin
                mem_q[index] <= replacement;
            end
        end
    end

endmodule

// File: rtl/cx_arbiter.sv
// Serialises per-core compare-and-exchange requests onto one shared register bank.
module cx_arbiter
    import cx_arbiter_pkg::*;
#(
    parameter int unsigned CORES       = CX_CORES,
    parameter int unsigned INDEX_BITS  = CX_INDEX_BITS,
    parameter int unsigned ROUND_ROBIN = 0
) (
    input logic         clock,
    input logic         reset,
    cx_arbiter_if.slave bus
);

    localparam int unsigned CoreW = (CORES > 1) ? $clog2(CORES) : 1;

    typedef logic [CoreW-1:0] core_idx_t;

    // Lowest requester wins, or in rotating mode the first requester after the last winner.
    function automatic core_idx_t pick_winner(input logic [CORES-1:0] req,
                                              input core_idx_t        last);
        core_idx_t win   = '0;
        logic      found = 1'b0;
        for (int unsigned k = 0; k < CORES; k++) begin
            core_idx_t c;
            if (ROUND_ROBIN != 0) begin
                c = core_idx_t'((32'(last) + 32'd1 + k) % CORES);
            end else begin
                c = core_idx_t'(k);
            end
            if (!found && req[c]) begin
                win   = c;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    cx_state_t             state_q, state_d;
    logic [INDEX_BITS-1:0] clear_index_q, clear_index_d;
    core_idx_t             last_grant_q, last_grant_d;
    logic [CORES-1:0]      grant_q, grant_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    regval_t               comparand_q, comparand_d;
    regval_t               replacement_q, replacement_d;
    regval_t               original_q, original_d;

    core_idx_t             winner;
    logic                  bank_enable;
    logic                  bank_write_zero;
    logic [INDEX_BITS-1:0] bank_index;
    regval_t               bank_original;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StClear;
            clear_index_q <= '0;
            last_grant_q  <= core_idx_t'(CORES - 1);
            grant_q       <= '0;
            index_q       <= '0;
            comparand_q   <= '0;
            replacement_q <= '0;
            original_q    <= '0;
        end else begin
            state_q       <= state_d;
            clear_index_q <= clear_index_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            index_q       <= index_d;
            comparand_q   <= comparand_d;
            replacement_q <= replacement_d;
            original_q    <= original_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clear_index_d = clear_index_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        index_d       = index_q;
        comparand_d   = comparand_q;
        replacement_d = replacement_q;
        original_d    = original_q;
        winner        = pick_winner(bus.request, last_grant_q);

        unique case (state_q)
            StClear: begin
                clear_index_d = clear_index_q + 1'b1;
                if (&clear_index_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (|bus.request) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_grant_d    = winner;
                    index_d         = bus.index[winner];
                    comparand_d     = bus.comparand[winner];
                    replacement_d   = bus.replacement[winner];
                    state_d         = StAccess;
                end
            end
            StAccess: begin
                state_d = StRespond;
            end
            StRespond: begin
                original_d = bank_original;
                grant_d    = '0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Reset wins over a coincident bank write so an aborted exchange never lands.
    assign bank_enable     = (state_q == StAccess) && !reset;
    assign bank_write_zero = (state_q == StClear) && !reset;
    assign bank_index      = (state_q == StClear) ? clear_index_q : index_q;

    cx_bank #(
        .INDEX_BITS (INDEX_BITS)
    ) u_bank (
        .clock       (clock),
        .enable      (bank_enable),
        .write_zero  (bank_write_zero),
        .index       (bank_index),
        .comparand   (comparand_q),
        .replacement (replacement_q),
        .original    (bank_original)
    );

    assign bus.ready    = (state_q == StIdle);
    assign bus.grant    = grant_q;
    assign bus.done     = (state_q == StRespond) ? grant_q : '0;
    assign bus.original = (state_q == StRespond) ? bank_original : original_q;
    assign bus.swapped  = (state_q == StRespond) && (bank_original == comparand_q);

    grant_onehot_a: assert property (@(posedge clock) disable iff (reset)
        $onehot0(grant_q));

    no_grant_in_clear_a: assert property (@(posedge clock) disable iff (reset)
        (state_q == StClear) |-> (grant_q == '0));

    access_then_respond_a: assert property (@(posedge clock) disable iff (reset)
        (state_q == StAccess) |=> (state_q == StRespond));

endmodule

// File: tb/tb_cx_arbiter.sv
// Randomised bench for cx_arbiter: fixed-priority and round-robin instances against a bank model.
module tb_cx_arbiter;
    import cx_arbiter_pkg::*;

    localparam int unsigned NC    = 4;
    localparam int unsigned IB    = 8;
    localparam int unsigned DEPTH = 2 ** IB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                          sel;
    logic    [NC-1:0]              req;
    logic    [NC-1:0][IB-1:0]      idx;
    regval_t [NC-1:0]              cmp;
    regval_t [NC-1:0]              rep;

    cx_arbiter_if #(.CORES(NC), .INDEX_BITS(IB)) bus_fx ();
    cx_arbiter_if #(.CORES(NC), .INDEX_BITS(IB)) bus_rr ();

    assign bus_fx.request     = sel ? '0 : req;
    assign bus_fx.index       = idx;
    assign bus_fx.comparand   = cmp;
    assign bus_fx.replacement = rep;
    assign bus_rr.request     = sel ? req : '0;
    assign bus_rr.index       = idx;
    assign bus_rr.comparand   = cmp;
    assign bus_rr.replacement = rep;

    cx_arbiter #(.CORES(NC), .INDEX_BITS(IB), .ROUND_ROBIN(0)) u_fx (
        .clock (clock),
        .reset (reset),
        .bus   (bus_fx)
    );

    cx_arbiter #(.CORES(NC), .INDEX_BITS(IB), .ROUND_ROBIN(1)) u_rr (
        .clock (clock),
        .reset (reset),
        .bus   (bus_rr)
    );

    logic [NC-1:0] o_grant, o_done;
    regval_t       o_orig;
    logic          o_swp, o_rdy;
    assign o_grant = sel ? bus_rr.grant    : bus_fx.grant;
    assign o_done  = sel ? bus_rr.done     : bus_fx.done;
    assign o_orig  = sel ? bus_rr.original : bus_fx.original;
    assign o_swp   = sel ? bus_rr.swapped  : bus_fx.swapped;
    assign o_rdy   = sel ? bus_rr.ready    : bus_fx.ready;

    // Model: one bank image and one last-winner per arbitration mode.
    regval_t     mdl_mem [2][DEPTH];
    int unsigned mdl_last [2];
    int unsigned ops_left [NC];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[m][i] = '0;
            mdl_last[m] = NC - 1;
        end
    endtask

    function automatic int unsigned mdl_pick(input logic [NC-1:0] m, input int unsigned mode);
        for (int unsigned k = 0; k < NC; k++) begin
            int unsigned c = (mode != 0) ? (mdl_last[mode] + 1 + k) % NC : k;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    task automatic new_op(input int unsigned c);
        idx[c] = ($urandom_range(0, 7) == 0) ? IB'($urandom) : IB'($urandom_range(0, 3));
        cmp[c] = ($urandom_range(0, 1) == 1) ? mdl_mem[sel][idx[c]] : regval_t'($urandom);
        rep[c] = $urandom;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (!o_rdy && n < 600) begin
            @(negedge clock);
            n++;
        end
        if (!o_rdy) check_eq({tag, "_ready_timeout"}, 32'(o_rdy), 1);
    endtask

    // Drives ops_left[] operations per core, checking every done pulse against the model.
    task automatic run_engine(input string tag, input bit fresh);
        int unsigned since = 0;
        int unsigned cyc   = 0;
        int unsigned w, ow;
        int unsigned waitg [NC];
        bit          first = 1'b1;
        regval_t     e_orig;
        wait_ready(tag);
        for (int unsigned c = 0; c < NC; c++) begin
            waitg[c] = 0;
            req[c]   = (ops_left[c] != 0);
            if (req[c] && fresh) new_op(c);
        end
        while (req != '0 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            since++;
            if (o_done != '0) begin
                w  = mdl_pick(req, 32'(sel));
                ow = 0;
                for (int unsigned c = 0; c < NC; c++) if (o_done[c]) ow = c;
                check_eq({tag, "_done"}, 32'(o_done), 32'(1) << w);
                check_eq({tag, "_grant"}, 32'(o_grant), 32'(1) << w);
                check_eq({tag, "_latency"}, since, first ? 2 : 3);
                check_eq({tag, "_ready_busy"}, 32'(o_rdy), 0);
                e_orig = mdl_mem[sel][idx[w]];
                check_eq({tag, "_original"}, o_orig, e_orig);
                check_eq({tag, "_swapped"}, 32'(o_swp), 32'(e_orig == cmp[w]));
                if (e_orig == cmp[w]) mdl_mem[sel][idx[w]] = rep[w];
                mdl_last[sel] = w;
                for (int unsigned c = 0; c < NC; c++) begin
                    if (c != ow && req[c]) begin
                        waitg[c]++;
                        if (sel) check_eq({tag, "_rr_bound"}, 32'(waitg[c] <= NC - 1), 1);
                    end
                end
                waitg[ow] = 0;
                ops_left[w]--;
                if (ops_left[w] == 0) req[w] = 1'b0;
                else new_op(w);
                since = 0;
                first = 1'b0;
            end
        end
        check_eq({tag, "_drained"}, 32'(req), 0);
        req = '0;
    endtask

    initial begin
        int unsigned cnt;
        bit          gbad;
        sel = 1'b0;
        req = '0;
        idx = '0;
        cmp = '0;
        rep = '0;
        for (int c = 0; c < NC; c++) ops_left[c] = 0;
        model_reset();

        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            sel = m[0];
            #1;
            check_eq("rst_ready", 32'(o_rdy), 0);
            check_eq("rst_grant", 32'(o_grant), 0);
            check_eq("rst_done", 32'(o_done), 0);
            check_eq("rst_swapped", 32'(o_swp), 0);
            check_eq("rst_original", o_orig, 0);
        end
        sel = 1'b0;
        @(negedge clock);

        // Request pending across the whole zero-fill.
        req[2] = 1'b1;
        idx[2] = IB'(200);
        cmp[2] = '0;
        rep[2] = 32'hCAFE_0001;
        reset  = 1'b0;
        cnt    = 0;
        gbad   = 1'b0;
        while (!o_rdy && cnt < 1000) begin
            if (o_grant != '0) gbad = 1'b1;
            cnt++;
            @(negedge clock);
        end
        check_eq("clear_cycles", cnt, DEPTH);
        check_eq("grant_during_clear", 32'(gbad), 0);
        check_eq("grant_first_idle_low", 32'(o_grant), 0);
        @(negedge clock);
        check_eq("grant_after_first_idle", 32'(o_grant), 32'h4);
        @(negedge clock);
        check_eq("clear_done", 32'(o_done), 32'h4);
        check_eq("clear_read_zero", o_orig, 0);
        check_eq("clear_read_swapped", 32'(o_swp), 1);
        mdl_mem[0][200] = 32'hCAFE_0001;
        mdl_last[0]     = 2;
        req             = '0;

        // Single core, same entry: swap, then failed compare, then read-back.
        idx[0] = IB'(5); cmp[0] = '0; rep[0] = 32'h1234_5678; ops_left[0] = 1;
        run_engine("t2_swap", 1'b0);
        idx[0] = IB'(5); cmp[0] = '0; rep[0] = 32'hFFFF_0000; ops_left[0] = 1;
        run_engine("t2_noswap", 1'b0);
        idx[0] = IB'(5); cmp[0] = 32'h1234_5678; rep[0] = 32'h1234_5678; ops_left[0] = 1;
        run_engine("t2_readback", 1'b0);

        // Two cores, same entry, same cycle.
        idx[0] = IB'(7); cmp[0] = '0; rep[0] = 32'hA; ops_left[0] = 1;
        idx[1] = IB'(7); cmp[1] = '0; rep[1] = 32'hB; ops_left[1] = 1;
        run_engine("t3_collide", 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NC; c++) ops_left[c] = $urandom_range(0, 3);
            if (ops_left[r % NC] == 0) ops_left[r % NC] = 1;
            run_engine("fx_rand", 1'b1);
        end

        // Request withdrawn while its exchange is in flight.
        wait_ready("drop");
        idx[3] = IB'(2); cmp[3] = mdl_mem[0][2]; rep[3] = 32'h5A5A_0003;
        req[3] = 1'b1;
        @(negedge clock);
        req[3] = 1'b0;
        @(negedge clock);
        check_eq("drop_done", 32'(o_done), 32'h8);
        check_eq("drop_original", o_orig, mdl_mem[0][2]);
        check_eq("drop_swapped", 32'(o_swp), 1);
        mdl_mem[0][2] = 32'h5A5A_0003;
        mdl_last[0]   = 3;

        // Round-robin instance.
        sel = 1'b1;
        #1;
        ops_left[0] = 4; ops_left[1] = 4;
        run_engine("t4_rr_alt", 1'b1);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NC; c++) ops_left[c] = $urandom_range(1, 4);
            run_engine("rr_rand", 1'b1);
        end

        // Reset while the exchange is in ACCESS.
        sel = 1'b0;
        #1;
        wait_ready("t6");
        idx[0] = IB'(9); cmp[0] = mdl_mem[0][9]; rep[0] = 32'hDEAD_BEEF;
        req[0] = 1'b1;
        @(negedge clock);
        check_eq("t6_grant_access", 32'(o_grant), 32'h1);
        reset = 1'b1;
        req   = '0;
        gbad  = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (o_done != '0) gbad = 1'b1;
        end
        reset = 1'b0;
        model_reset();
        cnt = 0;
        while (!o_rdy && cnt < 1000) begin
            if (o_done != '0) gbad = 1'b1;
            cnt++;
            @(negedge clock);
        end
        check_eq("t6_no_done", 32'(gbad), 0);
        check_eq("t6_clear_cycles", cnt, DEPTH);
        idx[0] = IB'(9); cmp[0] = '0; rep[0] = '0; ops_left[0] = 1;
        run_engine("t6_read", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
